// File: rtl/prbs_chk23_pkg.sv
// Shared constants, state type and bit helpers for the PRBS-23 checker.
package prbs_chk23_pkg;

  // x^23 + x^18 + 1
  localparam int POLY_LEN = 23;
  localparam int POLY_TAP = 18;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  // Number of set bits in a byte (0..8)
  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

  // Bit reversal of a byte
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_chk23_if.sv
// Byte stream in, per-byte error report and BER counters out.
interface prbs_chk23_if #(parameter int pCNT_W = 32);
  logic              ival;
  logic [7:0]        idat;
  logic              iclr;
  logic              oval;
  logic [3:0]        oerr_num;
  logic              olock;
  logic [pCNT_W-1:0] obit_cnt;
  logic [pCNT_W-1:0] oerr_cnt;

  modport master (
    output ival, idat, iclr,
    input  oval, oerr_num, olock, obit_cnt, oerr_cnt
  );

  modport slave (
    input  ival, idat, iclr,
    output oval, oerr_num, olock, obit_cnt, oerr_cnt
  );
endinterface

// File: rtl/prbs_chk23_byte_pred.sv
// Predicts the next 8 PRBS-23 bits from the 23-bit history.
// History layout: lfsr[0] is the newest bit, lfsr[22] the oldest.
// Because the short tap (18) exceeds the byte width, every predicted bit
// comes straight from the history with no intra-byte dependency.
module prbs_chk23_byte_pred
  import prbs_chk23_pkg::*;
#(
  parameter bit pMSB_FIRST = 1'b0
) (
  input  logic [POLY_LEN-1:0] lfsr,
  output logic [7:0]          pred,
  output logic [POLY_LEN-1:0] lfsr_next_pred
);

  // seq[k] is the k-th bit in time order of the upcoming byte
  logic [7:0] seq;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign seq[gi] = lfsr[POLY_TAP-1-gi] ^ lfsr[POLY_LEN-1-gi];
      // last bit in time ends up newest (index 0)
      assign lfsr_next_pred[7-gi] = seq[gi];
      if (pMSB_FIRST) begin : g_msb
        assign pred[7-gi] = seq[gi];
      end else begin : g_lsb
        assign pred[gi] = seq[gi];
      end
    end
  endgenerate

  assign lfsr_next_pred[POLY_LEN-1:8] = lfsr[POLY_LEN-9:0];

endmodule

// File: rtl/prbs_chk23.sv
// PRBS-23 receive checker: self-synchronises to the incoming byte stream,
// declares lock, and accumulates checked-bit and bit-error counts.
module prbs_chk23
  import prbs_chk23_pkg::*;
#(
  parameter int pDAT_W      = 8,
  parameter bit pMSB_FIRST  = 1'b0,
  parameter int pSYNC_BYTES = 16,
  parameter int pWIN_BYTES  = 64,
  parameter int pLOSS_BITS  = 16,
  parameter int pCNT_W      = 32
) (
  input logic        clk,
  input logic        rst,
  input logic        iclkena,
  prbs_chk23_if.slave bus
);

  localparam int          CLEAN_W   = $clog2(pSYNC_BYTES + 1);
  localparam int          WCNT_W    = $clog2(pWIN_BYTES + 1);
  localparam int          WERR_W    = $clog2(pLOSS_BITS + 8) + 1;
  localparam logic [4:0]  FILL_STEP = 5'(pDAT_W);
  localparam logic [4:0]  FILL_DONE = 5'd24;

  state_t              state_reg;
  logic [POLY_LEN-1:0] lfsr_reg;
  logic [4:0]          fill_reg;
  logic [CLEAN_W-1:0]  clean_reg;
  logic [WCNT_W-1:0]   win_cnt_reg;
  logic [WERR_W-1:0]   win_err_reg;
  logic                lock_reg;
  logic                oval_reg;
  logic [3:0]          err_num_reg;
  logic [pCNT_W-1:0]   bit_cnt_reg;
  logic [pCNT_W-1:0]   err_cnt_reg;

  logic                accept;
  logic [7:0]          pred;
  logic [POLY_LEN-1:0] lfsr_pred;
  logic [POLY_LEN-1:0] lfsr_rx;
  logic [7:0]          err_vec;
  logic [3:0]          err_num;
  logic [4:0]          fill_next;
  logic [WERR_W-1:0]   win_err_sum;
  logic [pCNT_W:0]     bit_sum;
  logic [pCNT_W:0]     err_sum;

  prbs_chk23_byte_pred #(.pMSB_FIRST(pMSB_FIRST)) u_pred (
    .lfsr           (lfsr_reg),
    .pred           (pred),
    .lfsr_next_pred (lfsr_pred)
  );

  assign accept      = iclkena & bus.ival;
  assign err_vec     = pred ^ bus.idat;
  assign err_num     = popcnt8(err_vec);
  // received byte converted to history order (newest bit at index 0)
  assign lfsr_rx     = {lfsr_reg[POLY_LEN-9:0], (pMSB_FIRST ? bus.idat : rev8(bus.idat))};
  assign fill_next   = fill_reg + FILL_STEP;
  assign win_err_sum = win_err_reg + WERR_W'(err_num);
  assign bit_sum     = {1'b0, bit_cnt_reg} + (pCNT_W+1)'(pDAT_W);
  assign err_sum     = {1'b0, err_cnt_reg} + (pCNT_W+1)'(err_num);

  // Sync FSM: history update, fill/clean/window counters and lock flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= SEARCH;
      lfsr_reg    <= '0;
      fill_reg    <= '0;
      clean_reg   <= '0;
      win_cnt_reg <= '0;
      win_err_reg <= '0;
      lock_reg    <= 1'b0;
    end else if (accept) begin
      case (state_reg)
        SEARCH: begin
          lfsr_reg <= lfsr_rx;
          fill_reg <= fill_next;
          if (fill_next >= FILL_DONE) begin
            state_reg <= VERIFY;
            clean_reg <= '0;
          end
        end
        VERIFY: begin
          lfsr_reg <= lfsr_rx;
          if (err_vec == 8'd0) begin
            clean_reg <= clean_reg + 1'b1;
            if (clean_reg == CLEAN_W'(pSYNC_BYTES - 1)) begin
              state_reg   <= LOCK;
              lock_reg    <= 1'b1;
              win_cnt_reg <= '0;
              win_err_reg <= '0;
            end
          end else begin
            state_reg <= SEARCH;
            fill_reg  <= '0;
          end
        end
        LOCK: begin
          // free-run so a single flipped bit is counted only once
          lfsr_reg <= lfsr_pred;
          if (win_err_sum >= WERR_W'(pLOSS_BITS)) begin
            state_reg <= SEARCH;
            fill_reg  <= '0;
            lock_reg  <= 1'b0;
          end else if (win_cnt_reg == WCNT_W'(pWIN_BYTES - 1)) begin
            win_cnt_reg <= '0;
            win_err_reg <= '0;
          end else begin
            win_cnt_reg <= win_cnt_reg + 1'b1;
            win_err_reg <= win_err_sum;
          end
        end
        default: begin
          state_reg <= SEARCH;
          fill_reg  <= '0;
          lock_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Per-byte report, one cycle after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oval_reg    <= 1'b0;
      err_num_reg <= '0;
    end else if (iclkena) begin
      oval_reg    <= bus.ival;
      err_num_reg <= bus.ival ? err_num : 4'd0;
    end
  end

  // BER counters: clear wins over counting, both saturate at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else if (iclkena) begin
      if (bus.iclr) begin
        bit_cnt_reg <= '0;
        err_cnt_reg <= '0;
      end else if (bus.ival && state_reg == LOCK) begin
        bit_cnt_reg <= bit_sum[pCNT_W] ? '1 : bit_sum[pCNT_W-1:0];
        err_cnt_reg <= err_sum[pCNT_W] ? '1 : err_sum[pCNT_W-1:0];
      end
    end
  end

  assign bus.oval     = oval_reg;
  assign bus.oerr_num = err_num_reg;
  assign bus.olock    = lock_reg;
  assign bus.obit_cnt = bit_cnt_reg;
  assign bus.oerr_cnt = err_cnt_reg;

endmodule
